ieee754_packer: RTL and testbench

// Output end of the FP adder datapath: accepts one 37-bit extended-format result
//   {sign, exp[7:0], hidden, frac[22:0], grs[3:0]} plus a mantissa carry-out bit.

---
 rtl/ieee754_packer.sv | 194 +++++++++++++++++++
 tb/tb_ieee754_packer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieee754_packer.sv
// Purpose : normalise (one shift per cycle), round-to-nearest-even and pack an
//           extended FP adder result into an IEEE754 single, with status flags.
// Latency : NaN/Inf 1 cycle; normal results 3 cycles plus one per NORM shift.
// Backpressure: one operation in flight; in_ready low from accept until the
//           result is taken; out_valid/out_data held while out_ready is low.
// Ports   : clk, rst (sync, active-high); in_valid/in_ready/in_data[36:0]/in_carry;
//           out_valid/out_ready/out_data[31:0]/out_ovf/out_inx/out_zero.
module ieee754_packer #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int GRS_W  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [EXP_W+FRAC_W+GRS_W+1:0]        in_data,
    input  logic                                 in_carry,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [EXP_W+FRAC_W:0]                out_data,
    output logic                                 out_ovf,
    output logic                                 out_inx,
    output logic                                 out_zero
);
    localparam int IN_W  = EXP_W + FRAC_W + GRS_W + 2;
    localparam int OUT_W = EXP_W + FRAC_W + 1;
    localparam int M_W   = FRAC_W + GRS_W + 2;   // {carry, hidden, frac, grs}
    localparam int E_W   = EXP_W + 1;            // extra bit for overflow detect
    localparam int CB    = M_W - 1;              // carry bit index
    localparam int HB    = M_W - 2;              // hidden bit index
    localparam int GB    = GRS_W - 1;            // guard bit index
    localparam logic [E_W-1:0]   E_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [OUT_W-1:0] QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    state_t             state_q, state_d;
    logic               s_q, s_d;
    logic [E_W-1:0]     e_q, e_d;
    logic [M_W-1:0]     m_q, m_d;
    logic               sticky_q, sticky_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_inx_q, out_inx_d;
    logic               out_zero_q, out_zero_d;

    // Rounding temporaries
    logic               rup;
    logic [M_W-1:0]     m_r;
    logic [E_W-1:0]     e_r;

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        e_d        = e_q;
        m_d        = m_q;
        sticky_d   = sticky_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        out_inx_d  = out_inx_q;
        out_zero_d = out_zero_q;
        rup        = 1'b0;
        m_r        = m_q;
        e_r        = e_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d        = in_data[IN_W-1];
                    e_d        = {1'b0, in_data[IN_W-2 -: EXP_W]};
                    m_d        = {in_carry, in_data[HB:0]};
                    sticky_d   = 1'b0;
                    out_ovf_d  = 1'b0;
                    out_inx_d  = 1'b0;
                    out_zero_d = 1'b0;
                    if (in_data[IN_W-2 -: EXP_W] == {EXP_W{1'b1}}) begin
                        // NaN loses its sign and payload; infinity passes through.
                        if (in_data[HB-1:GRS_W] != '0)
                            out_data_d = QNAN;
                        else
                            out_data_d = {in_data[IN_W-1], {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        state_d = OUT;
                    end else begin
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                if (m_q[CB]) begin
                    // Right shift keeps the lost bit alive in the sticky position.
                    m_d      = {1'b0, m_q[CB:2], m_q[1] | m_q[0]};
                    sticky_d = sticky_q | m_q[0];
                    e_d      = e_q + E_W'(1);
                    if (e_q + E_W'(1) == E_MAX) begin
                        out_data_d = {s_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        out_ovf_d  = 1'b1;
                        out_inx_d  = 1'b1;
                        state_d    = OUT;
                    end
                end else if (m_q[HB:0] == '0) begin
                    out_data_d = {s_q, {(OUT_W-1){1'b0}}};
                    out_zero_d = 1'b1;
                    out_inx_d  = sticky_q;
                    state_d    = OUT;
                end else if (e_q == '0 && m_q[HB]) begin
                    // Denormal-encoded input that is actually normal.
                    e_d     = E_W'(1);
                    state_d = ROUND;
                end else if (!m_q[HB] && e_q > E_W'(1)) begin
                    m_d = m_q << 1;
                    e_d = e_q - E_W'(1);
                end else begin
                    // Normalised, or out of exponent range: a denormal result.
                    if (!m_q[HB])
                        e_d = '0;
                    state_d = ROUND;
                end
            end

            ROUND: begin
                rup = m_q[GB] && ((|m_q[GB-1:0]) || m_q[GRS_W]);
                m_r = m_q + (M_W'(rup) << GRS_W);
                e_r = e_q;
                if (m_r[CB]) begin
                    m_r = m_r >> 1;
                    e_r = e_q + E_W'(1);
                end
                if (e_r == E_MAX) begin
                    out_data_d = {s_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    out_ovf_d  = 1'b1;
                    out_inx_d  = 1'b1;
                end else begin
                    // Rounding a denormal up into the normal range.
                    if (e_r == '0 && m_r[HB])
                        e_r = E_W'(1);
                    out_data_d = {s_q, e_r[EXP_W-1:0], m_r[HB-1 -: FRAC_W]};
                    out_inx_d  = sticky_q | (|m_q[GB:0]);
                end
                m_d     = m_r;
                e_d     = e_r;
                state_d = OUT;
            end

            OUT: begin
                if (out_ready)
                    state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= 1'b0;
            e_q         <= '0;
            m_q         <= '0;
            sticky_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_inx_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            e_q         <= e_d;
            m_q         <= m_d;
            sticky_q    <= sticky_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_inx_q   <= out_inx_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_inx   = out_inx_q;
    assign out_zero  = out_zero_q;
endmodule

// File: tb/tb_ieee754_packer.sv
module tb_ieee754_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [36:0] in_data;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_inx;
    logic        out_zero;

    int tests  = 0;
    int failed = 0;

    // Results captured by run_op
    logic [31:0] r_data;
    logic        r_ovf, r_inx, r_zero;
    int          r_lat;
    bit          r_tmo;

    ieee754_packer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_carry (in_carry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .out_inx  (out_inx),
        .out_zero (out_zero)
    );

    always #5 clk = ~clk;

    // Present one operation, wait for acceptance edge, then count edges
    // until out_valid appears (r_lat = edges after the accept edge).
    task automatic run_op(input logic s, input logic [7:0] exp, input logic carry,
                          input logic hidden, input logic [22:0] frac, input logic [3:0] grs);
        in_data  = {s, exp, hidden, frac, grs};
        in_carry = carry;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        r_lat = 0;
        r_tmo = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) begin
                r_tmo = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            r_lat++;
        end
        r_data = out_data;
        r_ovf  = out_ovf;
        r_inx  = out_inx;
        r_zero = out_zero;
        tests++;
        if (r_tmo) begin
            failed++;
            $display("FAIL timeout: out_valid never rose (in_data=%h)", in_data);
        end
    endtask

    // Let the pending result transfer and the packer return to idle.
    task automatic drain;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid && in_ready) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++;
        if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++;
        if (out_data !== 32'h0) begin failed++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
        tests++;
        if ({out_ovf, out_inx, out_zero} !== 3'b000) begin
            failed++; $display("FAIL reset_flags got=%b exp=000", {out_ovf, out_inx, out_zero});
        end
        rst = 1'b0;
    endtask

    task automatic test_carry_add;
        // 1.0 + 1.0 : mantissa carry, one right shift
        run_op(1'b0, 8'h7F, 1'b1, 1'b0, 23'h0, 4'h0);
        tests++;
        if (r_data !== 32'h40000000) begin failed++; $display("FAIL one_plus_one got=%h exp=40000000", r_data); end
        tests++;
        if (r_lat !== 3) begin failed++; $display("FAIL one_plus_one_latency got=%0d exp=3", r_lat); end
        tests++;
        if ({r_ovf, r_inx, r_zero} !== 3'b000) begin failed++; $display("FAIL one_plus_one_flags got=%b exp=000", {r_ovf, r_inx, r_zero}); end
        drain();
    endtask

    task automatic test_cancellation;
        // Only frac LSB set: 23 left shifts, exponent 7F-23 = 68
        run_op(1'b0, 8'h7F, 1'b0, 1'b0, 23'h1, 4'h0);
        tests++;
        if (r_data !== 32'h34000000) begin failed++; $display("FAIL cancel got=%h exp=34000000", r_data); end
        tests++;
        if (r_lat !== 25) begin failed++; $display("FAIL cancel_latency got=%0d exp=25", r_lat); end
        drain();
    endtask

    task automatic test_rne;
        // Exact tie, even LSB: stays 1.0, inexact
        run_op(1'b0, 8'h7F, 1'b0, 1'b1, 23'h0, 4'b1000);
        tests++;
        if (r_data !== 32'h3F800000 || r_inx !== 1'b1) begin
            failed++; $display("FAIL rne_tie_even got=%h inx=%b exp=3F800000 inx=1", r_data, r_inx);
        end
        tests++;
        if (r_lat !== 2) begin failed++; $display("FAIL rne_latency got=%0d exp=2", r_lat); end
        drain();
        // Exact tie, odd LSB: rounds up to even
        run_op(1'b0, 8'h7F, 1'b0, 1'b1, 23'h1, 4'b1000);
        tests++;
        if (r_data !== 32'h3F800002 || r_inx !== 1'b1) begin
            failed++; $display("FAIL rne_tie_odd got=%h inx=%b exp=3F800002 inx=1", r_data, r_inx);
        end
        drain();
        // Below half: truncate, inexact
        run_op(1'b1, 8'h80, 1'b0, 1'b1, 23'h3, 4'b0111);
        tests++;
        if (r_data !== 32'hC0000003 || r_inx !== 1'b1) begin
            failed++; $display("FAIL rne_below_half got=%h inx=%b exp=C0000003 inx=1", r_data, r_inx);
        end
        drain();
    endtask

    task automatic test_overflow;
        run_op(1'b0, 8'hFE, 1'b1, 1'b0, 23'h0, 4'h0);
        tests++;
        if (r_data !== 32'h7F800000 || r_ovf !== 1'b1 || r_inx !== 1'b1) begin
            failed++; $display("FAIL ovf_carry got=%h ovf=%b inx=%b exp=7F800000 ovf=1 inx=1", r_data, r_ovf, r_inx);
        end
        drain();
        // Rounding carry pushes exponent to 255
        run_op(1'b0, 8'hFE, 1'b0, 1'b1, 23'h7FFFFF, 4'b1100);
        tests++;
        if (r_data !== 32'h7F800000 || r_ovf !== 1'b1) begin
            failed++; $display("FAIL ovf_round got=%h ovf=%b exp=7F800000 ovf=1", r_data, r_ovf);
        end
        drain();
    endtask

    task automatic test_special;
        run_op(1'b1, 8'hFF, 1'b0, 1'b1, 23'h1, 4'h0);
        tests++;
        if (r_data !== 32'h7FC00000 || {r_ovf, r_inx, r_zero} !== 3'b000) begin
            failed++; $display("FAIL nan got=%h flags=%b exp=7FC00000 flags=000", r_data, {r_ovf, r_inx, r_zero});
        end
        tests++;
        if (r_lat !== 0) begin failed++; $display("FAIL nan_latency got=%0d exp=0", r_lat); end
        drain();
        run_op(1'b1, 8'hFF, 1'b0, 1'b1, 23'h0, 4'h0);
        tests++;
        if (r_data !== 32'hFF800000 || r_ovf !== 1'b0) begin
            failed++; $display("FAIL inf got=%h ovf=%b exp=FF800000 ovf=0", r_data, r_ovf);
        end
        drain();
        // exp=0 with hidden set is promoted to exponent 1
        run_op(1'b0, 8'h00, 1'b0, 1'b1, 23'h0, 4'h0);
        tests++;
        if (r_data !== 32'h00800000) begin failed++; $display("FAIL denorm_promote got=%h exp=00800000", r_data); end
        drain();
        // Smallest denormal stays denormal
        run_op(1'b0, 8'h01, 1'b0, 1'b0, 23'h1, 4'h0);
        tests++;
        if (r_data !== 32'h00000001 || r_zero !== 1'b0) begin
            failed++; $display("FAIL denorm_min got=%h zero=%b exp=00000001 zero=0", r_data, r_zero);
        end
        drain();
        run_op(1'b1, 8'h40, 1'b0, 1'b0, 23'h0, 4'h0);
        tests++;
        if (r_data !== 32'h80000000 || r_zero !== 1'b1 || r_inx !== 1'b0) begin
            failed++; $display("FAIL neg_zero got=%h zero=%b inx=%b exp=80000000 zero=1 inx=0", r_data, r_zero, r_inx);
        end
        drain();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        run_op(1'b0, 8'h81, 1'b0, 1'b1, 23'h123, 4'h0);
        tests++;
        if (r_data !== 32'h40800123) begin failed++; $display("FAIL bp_data got=%h exp=40800123", r_data); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h40800123) begin
                failed++;
                $display("FAIL bp_hold cyc=%0d got valid=%b rdy=%b data=%h exp valid=1 rdy=0 data=40800123",
                         i, out_valid, in_ready, out_data);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++; $display("FAIL bp_release got valid=%b rdy=%b exp valid=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_op;
        in_data  = {1'b0, 8'h7F, 1'b0, 23'h1, 4'h0};
        in_carry = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++; $display("FAIL rst_mid_op got valid=%b rdy=%b exp valid=0 rdy=1", out_valid, in_ready);
        end
        repeat (30) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_discard got valid=%b exp=0", out_valid); end
        // Packer still usable afterwards
        run_op(1'b0, 8'h7F, 1'b0, 1'b1, 23'h0, 4'h0);
        tests++;
        if (r_data !== 32'h3F800000 || r_inx !== 1'b0) begin
            failed++; $display("FAIL after_rst got=%h inx=%b exp=3F800000 inx=0", r_data, r_inx);
        end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_carry  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_carry_add();
        test_cancellation();
        test_rne();
        test_overflow();
        test_special();
        test_backpressure();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
